// File: rtl/tpu_sequencer.sv
// tpu_sequencer: host-side driver for the tpu core.
// Loads a 4x4 A and a 4x4 B operand block, issues the COMPUTE burst, then reads
// the 16 results back one at a time and streams them out with a last flag.
// Optional build macro TPU_SEQ_PERF_EN adds a saturating per-job cycle counter
// on port cycle_count.
module tpu_sequencer #(
  parameter int COMPUTE_CYCLES = 10,
  parameter int READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [15:0] instruction,
  input  logic [7:0]  result_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [15:0] cycle_count
`endif
);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD_A  = 3'b001;
  localparam logic [2:0] OP_LOAD_B  = 3'b010;
  localparam logic [2:0] OP_COMPUTE = 3'b011;
  localparam logic [2:0] OP_READ    = 3'b100;

  localparam logic [7:0] CC_LAST = 8'(COMPUTE_CYCLES - 1);
  localparam logic [7:0] RL_LAST = 8'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_A     = 3'd1,
    S_LOAD_B     = 3'd2,
    S_COMPUTE    = 3'd3,
    S_READ_ISSUE = 3'd4,
    S_READ_WAIT  = 3'd5,
    S_OUT        = 3'd6
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [3:0]  ridx_r, ridx_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [15:0] instr_r, instr_s;
  logic        in_ready_r, in_ready_s;
  logic        out_valid_r, out_valid_s;
  logic [7:0]  out_data_r, out_data_s;
  logic        out_last_r, out_last_s;
  logic        busy_r, busy_s;
  logic        in_hs_s;
  logic        out_hs_s;

  // in_ready_r is only ever high in load states, so it doubles as the state gate
  assign in_hs_s  = in_valid & in_ready_r;
  assign out_hs_s = out_valid_r & out_ready;

  // Next-state, next-instruction and result-capture decode
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    ridx_s      = ridx_r;
    cnt_s       = cnt_r;
    instr_s     = {OP_NOP, 13'h0000};
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    out_last_s  = out_last_r;
    busy_s      = busy_r;
    case (state_r)
      S_IDLE, S_LOAD_A: begin
        if (in_hs_s) begin
          instr_s = {OP_LOAD_A, 1'b0, idx_r, in_data};
          idx_s   = idx_r + 4'd1;
          busy_s  = 1'b1;
          if (state_r == S_IDLE) begin
            state_s = S_LOAD_A;
          end else if (idx_r == 4'd15) begin
            state_s = S_LOAD_B;
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_LOAD_B: begin
        if (in_hs_s) begin
          instr_s = {OP_LOAD_B, 1'b0, idx_r, in_data};
          idx_s   = idx_r + 4'd1;
          if (idx_r == 4'd15) begin
            state_s = S_COMPUTE;
            cnt_s   = 8'd0;
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_COMPUTE: begin
        instr_s = {OP_COMPUTE, 9'd0, cnt_r[3:0]};
        if (cnt_r == CC_LAST) begin
          state_s = S_READ_ISSUE;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_READ_ISSUE: begin
        instr_s = {OP_READ, 1'b0, ridx_r, 8'h00};
        state_s = S_READ_WAIT;
        cnt_s   = 8'd0;
      end
      S_READ_WAIT: begin
        if (cnt_r == RL_LAST) begin
          out_valid_s = 1'b1;
          out_data_s  = result_in;
          out_last_s  = (ridx_r == 4'd15);
          state_s     = S_OUT;
          cnt_s       = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_OUT: begin
        if (out_hs_s) begin
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
          ridx_s      = ridx_r + 4'd1;
          if (ridx_r == 4'd15) begin
            state_s = S_IDLE;
            busy_s  = 1'b0;
          end else begin
            state_s = S_READ_ISSUE;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s     = S_IDLE;
        idx_s       = 4'd0;
        ridx_s      = 4'd0;
        cnt_s       = 8'd0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
    in_ready_s = (state_s == S_IDLE) || (state_s == S_LOAD_A) || (state_s == S_LOAD_B);
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= 4'd0;
      ridx_r      <= 4'd0;
      cnt_r       <= 8'd0;
      instr_r     <= 16'h0000;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      ridx_r      <= ridx_s;
      cnt_r       <= cnt_s;
      instr_r     <= instr_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_last_r  <= out_last_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign instruction = instr_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_last    = out_last_r;
  assign busy        = busy_r;

`ifdef TPU_SEQ_PERF_EN
  logic [15:0] cycle_count_r;

  // Job cycle counter; the accepting cycle of byte 0 is the job's first busy cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_r <= 16'h0000;
    end else if ((state_r == S_IDLE) && in_hs_s) begin
      cycle_count_r <= 16'h0001;
    end else if (busy_r && (cycle_count_r != 16'hFFFF)) begin
      cycle_count_r <= cycle_count_r + 16'h0001;
    end else begin
      cycle_count_r <= cycle_count_r;
    end
  end

  assign cycle_count = cycle_count_r;
`endif

endmodule
